esc_pwm_generator: RTL and testbench
====================================

Name: esc_pwm_generator

Overview:
- Motor-side end of the throttle path. Takes the 8-bit processed throttle value and its completion strobe, and regenerates a fixed-period servo/ESC PWM pulse train.
- Pulse width: 1000 us + 4 us per count, which maps throttle 0..250 to 1000..2000 us high time.
- Runs on the 1 MHz us_clk, so one clock cycle is one microsecond.
- Double-buffered so updates never produce runt or stretched pulses; includes an arm gate and a loss-of-update failsafe.

Parameters:
- PERIOD_US, 2500, PWM period in us_clk cycles (400 Hz).
- MIN_PULSE_US, 1000, high time for throttle value 0.
- US_PER_COUNT, 4, additional high-time cycles per throttle count.
- MAX_VALUE, 250, clamp ceiling for value_in.
- TIMEOUT_PERIODS, 8, number of whole periods without value_valid before failsafe.

Ports:
- us_clk  input  1  1 MHz system clock; the block's only clock.
- reset  input  1  asynchronous, active-high reset.
- value_in  input  8  throttle value from the throttle controller.
- value_valid  input  1  one-cycle strobe (the controller's complete signal); capture value_in.
- arm  input  1  level; 1 = generate pulses, 0 = output held low once the current period ends.
- pwm_out  output  1  registered ESC PWM output.
- period_start  output  1  one-cycle pulse on the first high cycle of each period.
- running  output  1  high while in RUN.
- timeout  output  1  failsafe active; sticky until the next value_valid.

Behaviour:
- Reset (async, active-high):
  - Outputs: pwm_out=0, period_start=0, running=0, timeout=0.
  - Internal: state=IDLE, shadow=0, active_len=MIN_PULSE_US, period_cnt=0, stale_cnt=0.
  - Reset asserted mid-pulse drops pwm_out the same instant.
- Shadow register:
  - On a value_valid edge, shadow <= min(value_in, MAX_VALUE); timeout <= 0; stale_cnt <= 0.
  - Values 251..255 clamp to 250.
- Length arithmetic:
  - len = MIN_PULSE_US + US_PER_COUNT*shadow, computed in 16 bits (maximum 2000 < PERIOD_US).
  - Computed only at a period boundary.
- States: IDLE, RUN.
- IDLE:
  - pwm_out=0, running=0.
  - On an edge with arm=1, go to RUN and start a period at that edge. Latency from arm to first pwm_out high is 1 cycle.
- Period start (from IDLE, or in RUN at the edge where period_cnt==PERIOD_US-1 and arm=1):
  - period_cnt <= 0
  - active_len <= len(shadow as registered before this edge)
  - pwm_out <= 1, period_start <= 1, running <= 1
- Inside RUN, other edges:
  - period_cnt <= period_cnt+1
  - pwm_out <= (period_cnt+1 < active_len)
  - period_start <= 0
  - Result: pwm_out is high for exactly active_len consecutive cycles, and each period is exactly PERIOD_US cycles.
- Arm deassert:
  - Sampled only at the period boundary. If arm=0 there, go to IDLE and hold pwm_out=0.
  - A pulse in progress always completes; there is no truncation.
- Simultaneous value_valid and period boundary: the old shadow sets this period's active_len; the new value takes effect next period.
- Failsafe:
  - stale_cnt increments at each period boundary while no value_valid has arrived since the last increment.
  - When stale_cnt reaches TIMEOUT_PERIODS: shadow <= 0 and timeout <= 1, which yields minimum pulses.
  - value_valid on the same edge as the timeout wins (shadow loads, timeout stays 0).
  - stale_cnt saturates.
  - In IDLE, stale_cnt holds.

Decomposition:
- Shared defines (common header): REC_VAL_BIT_WIDTH=8, TRUE/FALSE, BYTE_ALL_ZERO, ESC period/min-pulse constants.
- One natural sub-module, esc_period_timer: period_cnt, boundary detect, and high-compare against active_len.
- The top level holds the shadow register, clamp, watchdog, and the IDLE/RUN FSM.

Test Plan:
- Reset, arm=1, no value -> 1 cycle after arm, pwm_out high for 1000 cycles then low for 1500; period_start once every 2500 cycles.
- value_valid with value_in=125 -> next full period high for 1500 cycles; value_in=255 -> clamped, high for 2000 cycles.
- value_valid with value_in=200 at cycle 700 of a 1000-cycle pulse -> current pulse stays 1000; next pulse is 1800.
- No value_valid for 8 periods after value 200 -> 9th period pulse is 1000 and timeout=1; next value_valid clears timeout.
- arm dropped at cycle 500 of a 1800-cycle pulse -> pulse completes (1800 cycles); pwm_out stays 0 and running=0 after the boundary.
- reset asserted mid-pulse -> pwm_out=0 immediately; after release with arm=1, pulse is 1000 (shadow cleared).

Source files
------------

// File: rtl/esc_pwm_generator_pkg.sv
// Shared constants, state encoding and pulse-length helper for the ESC PWM path.
package esc_pwm_generator_pkg;

    localparam int REC_VAL_BIT_WIDTH = 8;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [REC_VAL_BIT_WIDTH-1:0] BYTE_ALL_ZERO = '0;

    localparam int ESC_PERIOD_US       = 2500;
    localparam int ESC_MIN_PULSE_US    = 1000;
    localparam int ESC_US_PER_COUNT    = 4;
    localparam int ESC_MAX_VALUE       = 250;
    localparam int ESC_TIMEOUT_PERIODS = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } esc_state_t;

    function automatic logic [15:0] esc_pulse_len(
        input logic [REC_VAL_BIT_WIDTH-1:0] val,
        input int unsigned                  min_us,
        input int unsigned                  us_per_count
    );
        return 16'(min_us + us_per_count * 32'(val));
    endfunction

endpackage

// File: rtl/esc_pwm_generator_period_timer.sv
// Period counter with boundary detect; holds the latched pulse length and drives the PWM level.
module esc_period_timer
    import esc_pwm_generator_pkg::*;
#(
    parameter int PERIOD_US    = ESC_PERIOD_US,
    parameter int MIN_PULSE_US = ESC_MIN_PULSE_US
) (
    input  logic        us_clk,
    input  logic        reset,
    input  logic        start,
    input  logic        advance,
    input  logic [15:0] len_in,
    output logic        boundary,
    output logic        pwm
);

    localparam int CW = $clog2(PERIOD_US);

    logic [CW-1:0] period_cnt;
    logic [15:0]   active_len;
    logic [15:0]   next_cnt;

    assign boundary = (period_cnt == CW'(PERIOD_US - 1));
    assign next_cnt = 16'(period_cnt) + 16'd1;

    // Neither start nor advance means the FSM is parked: force the output low.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            period_cnt <= '0;
            active_len <= 16'(MIN_PULSE_US);
            pwm        <= FALSE;
        end else if (start) begin
            period_cnt <= '0;
            active_len <= len_in;
            pwm        <= TRUE;
        end else if (advance) begin
            period_cnt <= period_cnt + CW'(1);
            pwm        <= (next_cnt < active_len);
        end else begin
            pwm        <= FALSE;
        end
    end

endmodule

// File: rtl/esc_pwm_generator.sv
// ESC PWM regenerator: shadowed throttle value, arm gate, stale-update failsafe and IDLE/RUN FSM.
module esc_pwm_generator
    import esc_pwm_generator_pkg::*;
#(
    parameter int PERIOD_US       = ESC_PERIOD_US,
    parameter int MIN_PULSE_US    = ESC_MIN_PULSE_US,
    parameter int US_PER_COUNT    = ESC_US_PER_COUNT,
    parameter int MAX_VALUE       = ESC_MAX_VALUE,
    parameter int TIMEOUT_PERIODS = ESC_TIMEOUT_PERIODS
) (
    input  logic                         us_clk,
    input  logic                         reset,
    input  logic [REC_VAL_BIT_WIDTH-1:0] value_in,
    input  logic                         value_valid,
    input  logic                         arm,
    output logic                         pwm_out,
    output logic                         period_start,
    output logic                         running,
    output logic                         timeout
);

    localparam int SW = $clog2(TIMEOUT_PERIODS + 1);
    localparam logic [SW-1:0] STALE_LIMIT = SW'(TIMEOUT_PERIODS);
    localparam logic [REC_VAL_BIT_WIDTH-1:0] MAX_CODE = REC_VAL_BIT_WIDTH'(MAX_VALUE);

    esc_state_t state, next_state;

    logic [REC_VAL_BIT_WIDTH-1:0] shadow;
    logic [REC_VAL_BIT_WIDTH-1:0] value_clamped;
    logic [SW-1:0]                stale_cnt;
    logic [15:0]                  next_len;
    logic                         boundary;
    logic                         period_edge;
    logic                         start_period;
    logic                         advance;

    assign value_clamped = (value_in > MAX_CODE) ? MAX_CODE : value_in;
    assign next_len      = esc_pulse_len(shadow, MIN_PULSE_US, US_PER_COUNT);

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Arm is only honoured at a period boundary so a running pulse is never cut short.
    always_comb begin
        next_state   = state;
        start_period = FALSE;
        advance      = FALSE;
        period_edge  = FALSE;
        case (state)
            IDLE: begin
                if (arm) begin
                    next_state   = RUN;
                    start_period = TRUE;
                end
            end
            RUN: begin
                if (boundary) begin
                    period_edge = TRUE;
                    if (arm) start_period = TRUE;
                    else     next_state   = IDLE;
                end else begin
                    advance = TRUE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            period_start <= FALSE;
            running      <= FALSE;
        end else begin
            period_start <= start_period;
            running      <= (next_state == RUN);
        end
    end

    // A fresh value always beats the watchdog when both land on the same edge.
    always_ff @(posedge us_clk or posedge reset) begin
        if (reset) begin
            shadow    <= BYTE_ALL_ZERO;
            stale_cnt <= '0;
            timeout   <= FALSE;
        end else if (value_valid) begin
            shadow    <= value_clamped;
            stale_cnt <= '0;
            timeout   <= FALSE;
        end else if (period_edge && stale_cnt != STALE_LIMIT) begin
            stale_cnt <= stale_cnt + SW'(1);
            if (stale_cnt == STALE_LIMIT - SW'(1)) begin
                shadow  <= BYTE_ALL_ZERO;
                timeout <= TRUE;
            end
        end
    end

    esc_period_timer #(
        .PERIOD_US    (PERIOD_US),
        .MIN_PULSE_US (MIN_PULSE_US)
    ) u_period_timer (
        .us_clk   (us_clk),
        .reset    (reset),
        .start    (start_period),
        .advance  (advance),
        .len_in   (next_len),
        .boundary (boundary),
        .pwm      (pwm_out)
    );

endmodule

// File: tb/tb_esc_pwm_generator.sv
// Scoreboard bench for esc_pwm_generator: expected pulse widths queued at stimulus, checked at each falling edge.
module tb_esc_pwm_generator;

    localparam int PERIOD = 2500;

    logic       us_clk;
    logic       reset;
    logic [7:0] value_in;
    logic       value_valid;
    logic       arm;
    logic       pwm_out;
    logic       period_start;
    logic       running;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    int exp_q[$];
    int pulses_done = 0;

    int mon_cyc      = 0;
    int mon_hi       = 0;
    int mon_prev     = 0;
    int mon_last_ps  = 0;
    int mon_ps_armed = 0;

    esc_pwm_generator dut (
        .us_clk       (us_clk),
        .reset        (reset),
        .value_in     (value_in),
        .value_valid  (value_valid),
        .arm          (arm),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .running      (running),
        .timeout      (timeout)
    );

    initial begin
        us_clk = 1'b0;
        forever #500 us_clk = ~us_clk;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Pulse-width and period monitor, sampled on the inactive edge.
    always @(negedge us_clk) begin
        int e;
        mon_cyc++;
        if (reset) begin
            mon_hi       = 0;
            mon_prev     = 0;
            mon_ps_armed = 0;
        end else begin
            if (pwm_out) begin
                mon_hi++;
            end else if (mon_prev != 0) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_val("pulse_len", mon_hi, e);
                end else begin
                    check_val("pulse_unexpected", mon_hi, 0);
                end
                pulses_done++;
                mon_hi = 0;
            end
            mon_prev = int'(pwm_out);
            if (!running) mon_ps_armed = 0;
            if (period_start) begin
                check_val("ps_with_pwm", int'(pwm_out), 1);
                if (mon_ps_armed != 0) check_val("period_len", mon_cyc - mon_last_ps, PERIOD);
                mon_last_ps  = mon_cyc;
                mon_ps_armed = 1;
            end
        end
    end

    task automatic tick();
        @(posedge us_clk);
        #1;
    endtask

    task automatic send_value(input int v);
        value_in    = 8'(v);
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int n);
        int target;
        int guard;
        target = pulses_done + n;
        guard  = 0;
        while (pulses_done < target && guard < 2 * PERIOD * n + 100) begin
            tick();
            guard++;
        end
        if (pulses_done < target) check_val("wait_pulse_timeout", pulses_done, target);
    endtask

    task automatic wait_period_start();
        int guard;
        guard = 0;
        tick();
        while (!period_start && guard < 3 * PERIOD) begin
            tick();
            guard++;
        end
        if (!period_start) check_val("wait_ps_timeout", int'(period_start), 1);
    endtask

    initial begin
        int n;
        reset       = 1'b1;
        arm         = 1'b0;
        value_in    = 8'd0;
        value_valid = 1'b0;
        repeat (3) tick();
        check_val("rst_pwm", int'(pwm_out), 0);
        check_val("rst_ps", int'(period_start), 0);
        check_val("rst_running", int'(running), 0);
        check_val("rst_timeout", int'(timeout), 0);

        // Default value after reset: minimum pulses; 1-cycle arm latency.
        reset = 1'b0;
        tick();
        check_val("idle_pwm", int'(pwm_out), 0);
        check_val("idle_running", int'(running), 0);
        exp_q.push_back(1000);
        exp_q.push_back(1000);
        arm = 1'b1;
        check_val("pre_arm_pwm", int'(pwm_out), 0);
        tick();
        check_val("arm_pwm", int'(pwm_out), 1);
        check_val("arm_ps", int'(period_start), 1);
        check_val("arm_running", int'(running), 1);
        tick();
        check_val("ps_one_cycle", int'(period_start), 0);
        check_val("pwm_held", int'(pwm_out), 1);
        wait_pulses(2);

        // Update mid-pulse: current pulse unchanged, next one uses 200.
        wait_period_start();
        exp_q.push_back(1000);
        repeat (700) tick();
        send_value(200);
        exp_q.push_back(1800);
        wait_pulses(2);

        // Plain value and clamped value.
        send_value(125);
        exp_q.push_back(1500);
        check_val("valid_timeout_clear", int'(timeout), 0);
        wait_pulses(1);
        send_value(255);
        exp_q.push_back(2000);
        wait_pulses(1);

        // Failsafe: eight stale periods keep 200, then minimum pulse with timeout.
        send_value(200);
        for (int i = 0; i < 8; i++) exp_q.push_back(1800);
        exp_q.push_back(1000);
        wait_pulses(7);
        check_val("timeout_not_yet", int'(timeout), 0);
        wait_pulses(1);
        check_val("timeout_set", int'(timeout), 1);
        wait_pulses(1);
        send_value(50);
        check_val("timeout_cleared", int'(timeout), 0);
        exp_q.push_back(1200);

        // Value arriving on the boundary edge applies one period later.
        wait_period_start();
        repeat (PERIOD - 1) tick();
        value_in    = 8'd100;
        value_valid = 1'b1;
        tick();
        value_valid = 1'b0;
        check_val("boundary_ps", int'(period_start), 1);
        exp_q.push_back(1200);
        exp_q.push_back(1400);
        wait_pulses(2);

        // Arm dropped mid-pulse: pulse completes, FSM idles at the boundary.
        send_value(200);
        exp_q.push_back(1800);
        wait_period_start();
        repeat (500) tick();
        arm = 1'b0;
        n = 500;
        while (running && n < 2 * PERIOD) begin
            tick();
            n++;
        end
        check_val("disarm_cycles", n, PERIOD);
        check_val("disarm_pwm", int'(pwm_out), 0);
        repeat (3000) tick();
        check_val("idle_hold_pwm", int'(pwm_out), 0);
        check_val("idle_hold_running", int'(running), 0);

        // Reset mid-pulse drops the output at once and clears the shadow.
        arm = 1'b1;
        repeat (300) tick();
        check_val("pre_reset_pwm", int'(pwm_out), 1);
        reset = 1'b1;
        #1;
        check_val("async_rst_pwm", int'(pwm_out), 0);
        check_val("async_rst_running", int'(running), 0);
        repeat (2) tick();
        exp_q.push_back(1000);
        reset = 1'b0;
        wait_pulses(1);
        check_val("post_reset_timeout", int'(timeout), 0);

        check_val("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
